// File: rtl/rf_write_arbiter_if.sv
// Register-file write arbiter bus: pipeline writeback, mul/div result port,
// mul/div issue tracking, decode hazard query and the register-file write port.
interface rf_write_arbiter_if;
   // Pipeline writeback stage
   logic        PIPE_WB_VALID;
   logic [4:0]  PIPE_WB_ADDR;
   logic [31:0] PIPE_WB_DATA;
   logic        PIPE_HOLD;
   // Mul/div result port
   logic        MD_RES_VALID;
   logic [4:0]  MD_RES_ADDR;
   logic [31:0] MD_RES_DATA;
   logic        MD_RES_READY;
   // Mul/div issue
   logic        MD_ISSUE_VALID;
   logic [4:0]  MD_ISSUE_RD;
   // Decode hazard query
   logic        DEC_VALID;
   logic [4:0]  DEC_RS1;
   logic [4:0]  DEC_RS2;
   logic [4:0]  DEC_RD;
   logic        DEC_STALL;
   // Register-file write port
   logic        RF_WRITE_EN;
   logic [4:0]  RF_INADDRESS;
   logic [31:0] RF_IN;

   // Core side: drives requests, receives grants/stall and the RF write port
   modport master (
      output PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
      output MD_RES_VALID, MD_RES_ADDR, MD_RES_DATA,
      output MD_ISSUE_VALID, MD_ISSUE_RD,
      output DEC_VALID, DEC_RS1, DEC_RS2, DEC_RD,
      input  MD_RES_READY, DEC_STALL, PIPE_HOLD,
      input  RF_WRITE_EN, RF_INADDRESS, RF_IN
   );

   // Arbiter side
   modport slave (
      input  PIPE_WB_VALID, PIPE_WB_ADDR, PIPE_WB_DATA,
      input  MD_RES_VALID, MD_RES_ADDR, MD_RES_DATA,
      input  MD_ISSUE_VALID, MD_ISSUE_RD,
      input  DEC_VALID, DEC_RS1, DEC_RS2, DEC_RD,
      output MD_RES_READY, DEC_STALL, PIPE_HOLD,
      output RF_WRITE_EN, RF_INADDRESS, RF_IN
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Owns the single register-file write port. Arbitrates pipeline writeback
// against the mul/div result port with a starvation guard, registers the
// winning write, and tracks outstanding mul/div destinations for decode stalls.
module rf_write_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,   // 1..15 lost cycles before PIPE_HOLD
   parameter int unsigned CNT_W        = 4    // must hold STARVE_LIMIT
) (
   input logic               CLK,
   input logic               RESET,
   rf_write_arbiter_if.slave bus
);

   typedef enum logic {SRC_PIPE = 1'b0, SRC_MD = 1'b1} wr_src_e;

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic [31:0]      busy_q, busy_d;
   logic             we_q,   we_d;
   logic [4:0]       addr_q, addr_d;
   logic [31:0]      data_q, data_d;
   wr_src_e          src_q,  src_d;

   logic pipe_hold;
   logic md_grant;
   logic pipe_grant;

   // Arbitration: MD wins when the pipeline is idle or MD has starved long enough
   always_comb begin
      pipe_hold  = bus.MD_RES_VALID & (cnt_q == LIMIT);
      md_grant   = bus.MD_RES_VALID & (pipe_hold | ~bus.PIPE_WB_VALID);
      pipe_grant = bus.PIPE_WB_VALID & ~md_grant;
   end

   assign bus.PIPE_HOLD    = pipe_hold;
   assign bus.MD_RES_READY = md_grant;

   // Starvation counter: counts consecutive lost cycles of a pending MD result
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      cnt_d = '0;
      if (bus.MD_RES_VALID && !md_grant)
         cnt_d = (cnt_q == LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // Write staging: the granted request is registered; x0 targets are consumed silently
   always_comb begin
      we_d   = 1'b0;
      addr_d = addr_q;
      data_d = data_q;
      src_d  = src_q;
      if (md_grant) begin
         we_d   = |bus.MD_RES_ADDR;
         addr_d = bus.MD_RES_ADDR;
         data_d = bus.MD_RES_DATA;
         src_d  = SRC_MD;
      end else if (pipe_grant) begin
         we_d   = |bus.PIPE_WB_ADDR;
         addr_d = bus.PIPE_WB_ADDR;
         data_d = bus.PIPE_WB_DATA;
         src_d  = SRC_PIPE;
      end
   end

   // Scoreboard: retire on the edge that ends an MD-sourced write, issue sets (set wins)
   always_comb begin
      busy_d = busy_q;
      if (we_q && (src_q == SRC_MD))
         busy_d[addr_q] = 1'b0;
      if (bus.MD_ISSUE_VALID && (bus.MD_ISSUE_RD != 5'd0))
         busy_d[bus.MD_ISSUE_RD] = 1'b1;
   end

   // State registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         // NOTE: the busy array is a handful of flops, not a RAM, so it is reset like any register.
         busy_q <= '0;
         cnt_q  <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         src_q  <= SRC_PIPE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         src_q  <= src_d;
      end
   end

   assign bus.RF_WRITE_EN  = we_q;
   assign bus.RF_INADDRESS = addr_q;
   assign bus.RF_IN        = data_q;

   // Busy registers stay visible through their final write cycle so reads never race the commit
   assign bus.DEC_STALL = bus.DEC_VALID &
                          (busy_q[bus.DEC_RS1] | busy_q[bus.DEC_RS2] | busy_q[bus.DEC_RD]);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration and scoreboard rules.
module tb_rf_write_arbiter;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 4;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;
   int   total = 0;
   int   bad   = 0;

   rf_write_arbiter_if bus_if ();

   rf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus_if)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural reference model ----------------
   bit        m_busy [32];
   int        m_wait;      // consecutive cycles the pending MD result has lost
   bit        m_we;
   bit [4:0]  m_addr;
   bit [31:0] m_data;
   bit        m_from_md;
   bit        m_known;     // address/data contents are predictable

   function automatic bit mdl_hold();
      return bus_if.MD_RES_VALID && (m_wait == STARVE_LIMIT);
   endfunction

   function automatic bit mdl_md_grant();
      return bus_if.MD_RES_VALID && (mdl_hold() || !bus_if.PIPE_WB_VALID);
   endfunction

   function automatic bit mdl_stall();
      return bus_if.DEC_VALID && (m_busy[bus_if.DEC_RS1] || m_busy[bus_if.DEC_RS2] ||
                                  m_busy[bus_if.DEC_RD]);
   endfunction

   task automatic model_edge();
      bit md_g;
      bit pipe_g;
      if (RESET) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_wait = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_from_md = 1'b0; m_known = 1'b1;
      end else begin
         md_g   = mdl_md_grant();
         pipe_g = bus_if.PIPE_WB_VALID && !md_g;
         if (m_we && m_from_md) m_busy[m_addr] = 1'b0;
         if (bus_if.MD_ISSUE_VALID && bus_if.MD_ISSUE_RD != 0) m_busy[bus_if.MD_ISSUE_RD] = 1'b1;
         if (bus_if.MD_RES_VALID && !md_g) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
         else m_wait = 0;
         m_we = 1'b0;
         if (md_g || pipe_g) begin
            m_from_md = md_g;
            if ((md_g ? bus_if.MD_RES_ADDR : bus_if.PIPE_WB_ADDR) == 0) begin
               m_known = 1'b0;
            end else begin
               m_we    = 1'b1;
               m_known = 1'b1;
               m_addr  = md_g ? bus_if.MD_RES_ADDR : bus_if.PIPE_WB_ADDR;
               m_data  = md_g ? bus_if.MD_RES_DATA : bus_if.PIPE_WB_DATA;
            end
         end
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the edge
   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus_if.PIPE_WB_VALID = 1'b0; bus_if.PIPE_WB_ADDR = '0; bus_if.PIPE_WB_DATA = '0;
      bus_if.MD_RES_VALID  = 1'b0; bus_if.MD_RES_ADDR  = '0; bus_if.MD_RES_DATA  = '0;
      bus_if.MD_ISSUE_VALID = 1'b0; bus_if.MD_ISSUE_RD = '0;
      bus_if.DEC_VALID = 1'b0; bus_if.DEC_RS1 = '0; bus_if.DEC_RS2 = '0; bus_if.DEC_RD = '0;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd5;
      tick();
      bus_if.MD_ISSUE_VALID = 1'b0;
      bus_if.PIPE_WB_VALID = 1'b1; bus_if.PIPE_WB_ADDR = 5'd4; bus_if.PIPE_WB_DATA = 32'hA5A5_0004;
      tick();
      bus_if.DEC_VALID = 1'b1; bus_if.DEC_RS1 = 5'd5;
      #1;
      total++;
      if (bus_if.DEC_STALL !== 1'b1) begin
         bad++; $display("FAIL reset_pre_stall got=%b want=1", bus_if.DEC_STALL);
      end
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b1) begin
         bad++; $display("FAIL reset_pre_we got=%b want=1", bus_if.RF_WRITE_EN);
      end
      RESET = 1'b1;
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd6;
      tick();
      RESET = 1'b0;
      idle_inputs();
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b0) begin
         bad++; $display("FAIL reset_we got=%b want=0", bus_if.RF_WRITE_EN);
      end
      total++;
      if (bus_if.RF_INADDRESS !== 5'd0) begin
         bad++; $display("FAIL reset_addr got=%0d want=0", bus_if.RF_INADDRESS);
      end
      total++;
      if (bus_if.RF_IN !== 32'd0) begin
         bad++; $display("FAIL reset_data got=%h want=0", bus_if.RF_IN);
      end
      bus_if.DEC_VALID = 1'b1;
      for (int r = 0; r < 32; r++) begin
         bus_if.DEC_RS1 = 5'(r); bus_if.DEC_RS2 = 5'(r); bus_if.DEC_RD = 5'(r);
         #1;
         total++;
         if (bus_if.DEC_STALL !== 1'b0) begin
            bad++; $display("FAIL reset_stall_r%0d got=%b want=0", r, bus_if.DEC_STALL);
         end
      end
      idle_inputs();
   endtask

   task automatic test_pipe_write();
      bus_if.PIPE_WB_VALID = 1'b1; bus_if.PIPE_WB_ADDR = 5'd3; bus_if.PIPE_WB_DATA = 32'hDEAD_BEEF;
      #1;
      total++;
      if (bus_if.MD_RES_READY !== 1'b0 || bus_if.PIPE_HOLD !== 1'b0) begin
         bad++; $display("FAIL pipe_comb ready=%b hold=%b want 0/0", bus_if.MD_RES_READY, bus_if.PIPE_HOLD);
      end
      tick();
      bus_if.PIPE_WB_VALID = 1'b0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b1 || bus_if.RF_INADDRESS !== 5'd3 || bus_if.RF_IN !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL pipe_write got we=%b a=%0d d=%h want 1/3/deadbeef",
                         bus_if.RF_WRITE_EN, bus_if.RF_INADDRESS, bus_if.RF_IN);
      end
      tick();
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b0 || bus_if.RF_INADDRESS !== 5'd3 || bus_if.RF_IN !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL pipe_nogrant_hold got we=%b a=%0d d=%h want 0/3/deadbeef",
                         bus_if.RF_WRITE_EN, bus_if.RF_INADDRESS, bus_if.RF_IN);
      end
      bus_if.PIPE_WB_VALID = 1'b1; bus_if.PIPE_WB_ADDR = 5'd0; bus_if.PIPE_WB_DATA = 32'h5555_5555;
      tick();
      bus_if.PIPE_WB_VALID = 1'b0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b0) begin
         bad++; $display("FAIL pipe_x0_we got=%b want=0", bus_if.RF_WRITE_EN);
      end
      idle_inputs();
   endtask

   task automatic test_scoreboard();
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd7;
      tick();
      bus_if.MD_ISSUE_VALID = 1'b0;
      bus_if.DEC_VALID = 1'b1; bus_if.DEC_RS1 = 5'd7; bus_if.DEC_RS2 = 5'd1; bus_if.DEC_RD = 5'd2;
      #1;
      total++;
      if (bus_if.DEC_STALL !== 1'b1) begin
         bad++; $display("FAIL sb_raw_stall got=%b want=1", bus_if.DEC_STALL);
      end
      bus_if.MD_RES_VALID = 1'b1; bus_if.MD_RES_ADDR = 5'd7; bus_if.MD_RES_DATA = 32'h12;
      #1;
      total++;
      if (bus_if.MD_RES_READY !== 1'b1) begin
         bad++; $display("FAIL sb_md_ready got=%b want=1", bus_if.MD_RES_READY);
      end
      tick();
      bus_if.MD_RES_VALID = 1'b0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b1 || bus_if.RF_INADDRESS !== 5'd7 || bus_if.RF_IN !== 32'h12) begin
         bad++; $display("FAIL sb_md_write got we=%b a=%0d d=%h want 1/7/12",
                         bus_if.RF_WRITE_EN, bus_if.RF_INADDRESS, bus_if.RF_IN);
      end
      total++;
      if (bus_if.DEC_STALL !== 1'b1) begin
         bad++; $display("FAIL sb_stall_during_write got=%b want=1", bus_if.DEC_STALL);
      end
      tick();
      total++;
      if (bus_if.DEC_STALL !== 1'b0) begin
         bad++; $display("FAIL sb_stall_released got=%b want=0", bus_if.DEC_STALL);
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      bus_if.PIPE_WB_VALID = 1'b1; bus_if.PIPE_WB_ADDR = 5'd2; bus_if.PIPE_WB_DATA = 32'h0000_2222;
      bus_if.MD_RES_VALID  = 1'b1; bus_if.MD_RES_ADDR  = 5'd10; bus_if.MD_RES_DATA = 32'h0000_A0A0;
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         #1;
         total++;
         if (bus_if.MD_RES_READY !== 1'b0 || bus_if.PIPE_HOLD !== 1'b0) begin
            bad++; $display("FAIL starve_lose_c%0d ready=%b hold=%b want 0/0",
                            i, bus_if.MD_RES_READY, bus_if.PIPE_HOLD);
         end
         tick();
         bus_if.PIPE_WB_ADDR = 5'(3 + i); bus_if.PIPE_WB_DATA = $urandom;
      end
      #1;
      total++;
      if (bus_if.MD_RES_READY !== 1'b1 || bus_if.PIPE_HOLD !== 1'b1) begin
         bad++; $display("FAIL starve_win ready=%b hold=%b want 1/1", bus_if.MD_RES_READY, bus_if.PIPE_HOLD);
      end
      tick();
      bus_if.MD_RES_ADDR = 5'd11; bus_if.MD_RES_DATA = 32'h0000_B0B0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b1 || bus_if.RF_INADDRESS !== 5'd10 || bus_if.RF_IN !== 32'h0000_A0A0) begin
         bad++; $display("FAIL starve_md_write got we=%b a=%0d d=%h want 1/10/a0a0",
                         bus_if.RF_WRITE_EN, bus_if.RF_INADDRESS, bus_if.RF_IN);
      end
      #1;
      total++;
      if (bus_if.MD_RES_READY !== 1'b0 || bus_if.PIPE_HOLD !== 1'b0) begin
         bad++; $display("FAIL starve_cnt_cleared ready=%b hold=%b want 0/0",
                         bus_if.MD_RES_READY, bus_if.PIPE_HOLD);
      end
      tick();
      bus_if.MD_RES_VALID = 1'b0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b1 || bus_if.RF_INADDRESS !== 5'(3 + STARVE_LIMIT - 1)) begin
         bad++; $display("FAIL starve_held_pipe got we=%b a=%0d want 1/%0d",
                         bus_if.RF_WRITE_EN, bus_if.RF_INADDRESS, 3 + STARVE_LIMIT - 1);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_same_edge();
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd9;
      tick();
      bus_if.MD_ISSUE_VALID = 1'b0;
      bus_if.MD_RES_VALID = 1'b1; bus_if.MD_RES_ADDR = 5'd9; bus_if.MD_RES_DATA = 32'h99;
      tick();
      bus_if.MD_RES_VALID = 1'b0;
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd9;
      tick();
      bus_if.MD_ISSUE_VALID = 1'b0;
      bus_if.DEC_VALID = 1'b1; bus_if.DEC_RS1 = 5'd0; bus_if.DEC_RS2 = 5'd0; bus_if.DEC_RD = 5'd9;
      #1;
      total++;
      if (bus_if.DEC_STALL !== 1'b1) begin
         bad++; $display("FAIL same_edge_set_wins got=%b want=1", bus_if.DEC_STALL);
      end
      bus_if.MD_RES_VALID = 1'b1; bus_if.MD_RES_DATA = 32'h9A;
      tick();
      bus_if.MD_RES_VALID = 1'b0;
      tick();
      total++;
      if (bus_if.DEC_STALL !== 1'b0) begin
         bad++; $display("FAIL same_edge_retire got=%b want=0", bus_if.DEC_STALL);
      end
      idle_inputs();
   endtask

   task automatic test_x0();
      bus_if.MD_ISSUE_VALID = 1'b1; bus_if.MD_ISSUE_RD = 5'd12;
      tick();
      bus_if.MD_ISSUE_VALID = 1'b0;
      bus_if.MD_RES_VALID = 1'b1; bus_if.MD_RES_ADDR = 5'd0; bus_if.MD_RES_DATA = 32'hFFFF_0000;
      #1;
      total++;
      if (bus_if.MD_RES_READY !== 1'b1) begin
         bad++; $display("FAIL x0_ready got=%b want=1", bus_if.MD_RES_READY);
      end
      tick();
      bus_if.MD_RES_VALID = 1'b0;
      total++;
      if (bus_if.RF_WRITE_EN !== 1'b0) begin
         bad++; $display("FAIL x0_we got=%b want=0", bus_if.RF_WRITE_EN);
      end
      tick();
      bus_if.DEC_VALID = 1'b1; bus_if.DEC_RS1 = 5'd0; bus_if.DEC_RS2 = 5'd0; bus_if.DEC_RD = 5'd12;
      #1;
      total++;
      if (bus_if.DEC_STALL !== 1'b1) begin
         bad++; $display("FAIL x0_busy12_kept got=%b want=1", bus_if.DEC_STALL);
      end
      bus_if.DEC_RD = 5'd0;
      #1;
      total++;
      if (bus_if.DEC_STALL !== 1'b0) begin
         bad++; $display("FAIL x0_busy0_clear got=%b want=0", bus_if.DEC_STALL);
      end
      bus_if.MD_RES_VALID = 1'b1; bus_if.MD_RES_ADDR = 5'd12; bus_if.MD_RES_DATA = 32'hC;
      tick();
      idle_inputs();
      tick();
   endtask

   // ---------------- randomized traffic vs. model ----------------
   task automatic test_random();
      bit md_pend   = 1'b0;
      bit pipe_keep = 1'b0;
      bit md_g;
      for (int n = 0; n < 3000; n++) begin
         RESET = ($urandom_range(0, 149) == 0);
         if (!pipe_keep) begin
            bus_if.PIPE_WB_VALID = 1'($urandom_range(0, 1));
            bus_if.PIPE_WB_ADDR  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus_if.PIPE_WB_DATA  = $urandom;
         end
         if (!md_pend && $urandom_range(0, 2) == 0) begin
            md_pend = 1'b1;
            bus_if.MD_RES_ADDR = 5'($urandom_range(0, 15));
            bus_if.MD_RES_DATA = $urandom;
         end
         bus_if.MD_RES_VALID   = md_pend;
         bus_if.MD_ISSUE_VALID = ($urandom_range(0, 3) == 0);
         bus_if.MD_ISSUE_RD    = 5'($urandom_range(0, 15));
         bus_if.DEC_VALID      = 1'($urandom_range(0, 1));
         bus_if.DEC_RS1        = 5'($urandom_range(0, 15));
         bus_if.DEC_RS2        = 5'($urandom_range(0, 15));
         bus_if.DEC_RD         = 5'($urandom_range(0, 15));
         #1;
         total++;
         if (bus_if.MD_RES_READY !== mdl_md_grant()) begin
            bad++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, bus_if.MD_RES_READY, mdl_md_grant());
         end
         total++;
         if (bus_if.PIPE_HOLD !== mdl_hold()) begin
            bad++; $display("FAIL rnd_hold n=%0d got=%b want=%b", n, bus_if.PIPE_HOLD, mdl_hold());
         end
         total++;
         if (bus_if.DEC_STALL !== mdl_stall()) begin
            bad++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, bus_if.DEC_STALL, mdl_stall());
         end
         md_g      = mdl_md_grant();
         pipe_keep = bus_if.PIPE_WB_VALID && md_g && !RESET;
         if (md_g || RESET) md_pend = 1'b0;
         tick();
         total++;
         if (bus_if.RF_WRITE_EN !== m_we) begin
            bad++; $display("FAIL rnd_we n=%0d got=%b want=%b", n, bus_if.RF_WRITE_EN, m_we);
         end
         if (m_known) begin
            total++;
            if (bus_if.RF_INADDRESS !== m_addr || bus_if.RF_IN !== m_data) begin
               bad++; $display("FAIL rnd_wdata n=%0d got a=%0d d=%h want a=%0d d=%h",
                               n, bus_if.RF_INADDRESS, bus_if.RF_IN, m_addr, m_data);
            end
         end
      end
      RESET = 1'b0;
      idle_inputs();
      tick();
   endtask

   initial begin
      idle_inputs();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      test_reset();
      test_pipe_write();
      test_scoreboard();
      test_starvation();
      test_same_edge();
      test_x0();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
